// File: rtl/rf_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter_pkg
// Brief    : Shared widths and grant-source encoding for the RF write arbiter.
// Revision : 1.0
// ============================================================================
package rf_wb_arbiter_pkg;

  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_MDU  = 2'd2,
    GNT_SKID = 2'd3
  } gnt_src_e;

endpackage
`default_nettype wire

// File: rtl/rf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter_if
// Brief    : WB / MDU / issue / hazard / register-file signals of the arbiter.
// Revision : 1.0
// ============================================================================
interface rf_wb_arbiter_if;
  import rf_wb_arbiter_pkg::*;

  logic                 pipe_wb_valid;
  logic [REG_IDX_W-1:0] pipe_wb_rd;
  logic [XLEN-1:0]      pipe_wb_data;
  logic                 mdu_valid;
  logic [REG_IDX_W-1:0] mdu_rd;
  logic [XLEN-1:0]      mdu_data;
  logic                 mdu_ready;
  logic                 issue_valid;
  logic [REG_IDX_W-1:0] issue_rd;
  logic                 issue_ready;
  logic [REG_IDX_W-1:0] rs1_idx;
  logic [REG_IDX_W-1:0] rs2_idx;
  logic                 rs1_busy;
  logic                 rs2_busy;
  logic                 stall_req;
  logic                 rf_we;
  logic [REG_IDX_W-1:0] rf_rd;
  logic [XLEN-1:0]      rf_din;

  modport slave (
    input  pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    input  mdu_valid, mdu_rd, mdu_data,
    output mdu_ready,
    input  issue_valid, issue_rd,
    output issue_ready,
    input  rs1_idx, rs2_idx,
    output rs1_busy, rs2_busy,
    output stall_req, rf_we, rf_rd, rf_din
  );

  modport master (
    output pipe_wb_valid, pipe_wb_rd, pipe_wb_data,
    output mdu_valid, mdu_rd, mdu_data,
    input  mdu_ready,
    output issue_valid, issue_rd,
    input  issue_ready,
    output rs1_idx, rs2_idx,
    input  rs1_busy, rs2_busy,
    input  stall_req, rf_we, rf_rd, rf_din
  );

endinterface
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : rf_scoreboard
// Brief    : Per-register busy bits for in-flight MDU results.
// Revision : 1.0
// ============================================================================
module rf_scoreboard
  import rf_wb_arbiter_pkg::*;
(
  input  wire logic                 clk,
  input  wire logic                 reset,
  input  wire logic                 i_issue_valid,
  input  wire logic [REG_IDX_W-1:0] i_issue_rd,
  output logic                      o_issue_ready,
  input  wire logic                 i_clr_en,
  input  wire logic [REG_IDX_W-1:0] i_clr_idx,
  input  wire logic [REG_IDX_W-1:0] i_rs1_idx,
  input  wire logic [REG_IDX_W-1:0] i_rs2_idx,
  output logic                      o_rs1_busy,
  output logic                      o_rs2_busy
);

  logic [NUM_REGS-1:0] r_busy;
  logic                w_set;

  // x0 is never marked busy, so lookups and issue of x0 fall out naturally.
  assign o_issue_ready = ~r_busy[i_issue_rd];
  assign w_set         = i_issue_valid & o_issue_ready & (i_issue_rd != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      if (i_clr_en) r_busy[i_clr_idx] <= 1'b0;
      if (w_set)    r_busy[i_issue_rd] <= 1'b1;
    end
  end

  assign o_rs1_busy = r_busy[i_rs1_idx];
  assign o_rs2_busy = r_busy[i_rs2_idx];

endmodule
`default_nettype wire

// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Brief    : Register-file write-port arbiter: WB pipe vs MDU with skid/starve.
// Revision : 1.0
// ============================================================================
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
)(
  input  wire logic        clk,
  input  wire logic        reset,
  rf_wb_arbiter_if.slave   bus
);

  typedef enum logic [0:0] {
    ST_OPEN = 1'b0,
    ST_SKID = 1'b1
  } state_e;

  state_e               r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
  logic [REG_IDX_W-1:0] r_skid_rd;
  logic [XLEN-1:0]      r_skid_data;
  logic                 r_we;
  logic [REG_IDX_W-1:0] r_rd;
  logic [XLEN-1:0]      r_din;

  gnt_src_e             w_gnt;
  logic                 w_mdu_ready;
  logic                 w_skid_load;
  logic                 w_pipe_req;
  logic                 w_starved;
  logic                 w_we;
  logic [REG_IDX_W-1:0] w_wr_rd;
  logic [XLEN-1:0]      w_wr_data;

  // A pipe write to x0 is discarded before arbitration so it never blocks the MDU.
  assign w_pipe_req = bus.pipe_wb_valid & (bus.pipe_wb_rd != '0);
  assign w_starved  = (r_cnt == CNT_W'(STARVE_LIMIT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_OPEN;
      r_cnt       <= '0;
      r_skid_rd   <= '0;
      r_skid_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_skid_load) begin
        r_skid_rd   <= bus.pipe_wb_rd;
        r_skid_data <= bus.pipe_wb_data;
      end
    end
  end

  always_comb begin
    w_gnt       = GNT_NONE;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_skid_load = 1'b0;
    w_mdu_ready = 1'b0;
    case (r_state)
      ST_SKID: begin
        w_gnt       = GNT_SKID;
        w_state_nxt = ST_OPEN;
      end
      default: begin
        if (bus.mdu_valid && w_pipe_req && w_starved) begin
          // Forced MDU grant: the displaced pipe write parks in the skid.
          w_gnt       = GNT_MDU;
          w_mdu_ready = 1'b1;
          w_skid_load = 1'b1;
          w_state_nxt = ST_SKID;
          w_cnt_nxt   = '0;
        end else if (w_pipe_req) begin
          w_gnt = GNT_PIPE;
          if (bus.mdu_valid) w_cnt_nxt = r_cnt + CNT_W'(1);
        end else if (bus.mdu_valid) begin
          w_gnt       = GNT_MDU;
          w_mdu_ready = 1'b1;
          w_cnt_nxt   = '0;
        end
      end
    endcase
  end

  always_comb begin
    w_we      = 1'b0;
    w_wr_rd   = '0;
    w_wr_data = '0;
    case (w_gnt)
      GNT_PIPE: begin
        w_we      = 1'b1;
        w_wr_rd   = bus.pipe_wb_rd;
        w_wr_data = bus.pipe_wb_data;
      end
      GNT_MDU: begin
        w_we      = (bus.mdu_rd != '0);
        w_wr_rd   = bus.mdu_rd;
        w_wr_data = bus.mdu_data;
      end
      GNT_SKID: begin
        w_we      = 1'b1;
        w_wr_rd   = r_skid_rd;
        w_wr_data = r_skid_data;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_we  <= 1'b0;
      r_rd  <= '0;
      r_din <= '0;
    end else begin
      r_we <= w_we;
      if (w_we) begin
        r_rd  <= w_wr_rd;
        r_din <= w_wr_data;
      end
    end
  end

  rf_scoreboard u_scoreboard (
    .clk           (clk),
    .reset         (reset),
    .i_issue_valid (bus.issue_valid),
    .i_issue_rd    (bus.issue_rd),
    .o_issue_ready (bus.issue_ready),
    .i_clr_en      (w_gnt == GNT_MDU),
    .i_clr_idx     (bus.mdu_rd),
    .i_rs1_idx     (bus.rs1_idx),
    .i_rs2_idx     (bus.rs2_idx),
    .o_rs1_busy    (bus.rs1_busy),
    .o_rs2_busy    (bus.rs2_busy)
  );

  assign bus.mdu_ready = w_mdu_ready;
  assign bus.stall_req = (r_state == ST_SKID);
  assign bus.rf_we     = r_we;
  assign bus.rf_rd     = r_rd;
  assign bus.rf_din    = r_din;

endmodule
`default_nettype wire

// File: tb/tb_rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rf_wb_arbiter
// Brief    : Directed self-checking bench for rf_wb_arbiter.
// Revision : 1.0
// ============================================================================
module tb_rf_wb_arbiter;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;
  logic [31:0] r_shadow_busy;

  rf_wb_arbiter_if bus ();

  rf_wb_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow of issued-but-unreturned destinations, used only to police WAW.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_shadow_busy <= '0;
    end else begin
      if (bus.mdu_valid && bus.mdu_ready) r_shadow_busy[bus.mdu_rd] <= 1'b0;
      if (bus.issue_valid && bus.issue_ready && bus.issue_rd != 5'd0)
        r_shadow_busy[bus.issue_rd] <= 1'b1;
      if (bus.pipe_wb_valid && bus.pipe_wb_rd != 5'd0)
        assert (!r_shadow_busy[bus.pipe_wb_rd]) else $error("WAW pipe write to busy rd %0d", bus.pipe_wb_rd);
    end
  end

  task automatic drive_idle();
    bus.pipe_wb_valid = 1'b0; bus.pipe_wb_rd = '0; bus.pipe_wb_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_idle();
    bus.rs1_idx = 5'd7; bus.rs2_idx = 5'd0;
    repeat (2) @(negedge clk);
    n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %0b want 0", bus.rf_we); end
    n_cmp++; if (bus.rf_rd !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d want 0", bus.rf_rd); end
    n_cmp++; if (bus.rf_din !== 32'd0) begin n_fail++; $display("FAIL reset_din: got %h want 0", bus.rf_din); end
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", bus.stall_req); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy7: got %0b want 0", bus.rs1_busy); end
    reset = 1'b1;
  endtask

  task automatic test_pipe_only(input string tag);
    @(negedge clk);
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd5; bus.pipe_wb_data = 32'h0000_A5A5;
    #1;
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL %s_stall0: got %0b want 0", tag, bus.stall_req); end
    @(negedge clk);
    drive_idle();
    n_cmp++; if (bus.rf_we !== 1'b1) begin n_fail++; $display("FAIL %s_we: got %0b want 1", tag, bus.rf_we); end
    n_cmp++; if (bus.rf_rd !== 5'd5) begin n_fail++; $display("FAIL %s_rd: got %0d want 5", tag, bus.rf_rd); end
    n_cmp++; if (bus.rf_din !== 32'h0000_A5A5) begin n_fail++; $display("FAIL %s_din: got %h want 0000a5a5", tag, bus.rf_din); end
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL %s_stall1: got %0b want 0", tag, bus.stall_req); end
    @(negedge clk);
    n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL %s_we_off: got %0b want 0", tag, bus.rf_we); end
  endtask

  task automatic test_scoreboard();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1_idx = 5'd7; bus.rs2_idx = 5'd0;
    #1;
    n_cmp++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL sb_issue_ok: got %0b want 1", bus.issue_ready); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_pre_busy: got %0b want 0", bus.rs1_busy); end
    @(negedge clk);
    #1;
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy7: got %0b want 1", bus.rs1_busy); end
    n_cmp++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL sb_reissue_block: got %0b want 0", bus.issue_ready); end
    n_cmp++; if (bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL sb_x0_busy: got %0b want 0", bus.rs2_busy); end
    @(negedge clk);
    bus.issue_valid = 1'b0;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd7; bus.mdu_data = 32'h0000_1234;
    #1;
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL sb_mdu_ready: got %0b want 1", bus.mdu_ready); end
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL sb_busy_grant_cyc: got %0b want 1", bus.rs1_busy); end
    @(negedge clk);
    drive_idle();
    n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd7) begin n_fail++; $display("FAIL sb_wr: got we=%0b rd=%0d want we=1 rd=7", bus.rf_we, bus.rf_rd); end
    n_cmp++; if (bus.rf_din !== 32'h0000_1234) begin n_fail++; $display("FAIL sb_din: got %h want 00001234", bus.rf_din); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL sb_cleared: got %0b want 0", bus.rs1_busy); end
  endtask

  // Pipe rd base..base+4 every cycle against one MDU result for rd 3.
  task automatic run_starve(input logic [4:0] base, input bit check);
    @(negedge clk);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd3; bus.mdu_data = 32'h0000_0033;
    for (int i = 0; i < 5; i++) begin
      bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = base + 5'(i); bus.pipe_wb_data = 32'h100 + 32'(i);
      #1;
      if (check) begin
        n_cmp++; if (bus.mdu_ready !== (i == 4)) begin n_fail++; $display("FAIL starve_ready[%0d]: got %0b want %0b", i, bus.mdu_ready, (i == 4)); end
      end
      @(negedge clk);
      if (check) begin
        n_cmp++;
        if (bus.rf_we !== 1'b1 || bus.rf_rd !== ((i < 4) ? base + 5'(i) : 5'd3)) begin
          n_fail++; $display("FAIL starve_rd[%0d]: got we=%0b rd=%0d want rd=%0d", i, bus.rf_we, bus.rf_rd, (i < 4) ? base + 5'(i) : 5'd3);
        end
      end
    end
    drive_idle();
  endtask

  task automatic test_starvation();
    run_starve(5'd10, 1'b1);
    // Skid cycle: a fresh MDU result must be refused while the skid drains.
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd6; bus.mdu_data = 32'h0000_0066;
    #1;
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %0b want 1", bus.stall_req); end
    n_cmp++; if (bus.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL starve_skid_ready: got %0b want 0", bus.mdu_ready); end
    @(negedge clk);
    n_cmp++; if (bus.rf_rd !== 5'd14 || bus.rf_din !== 32'h104) begin n_fail++; $display("FAIL starve_skid_wr: got rd=%0d din=%h want rd=14 din=104", bus.rf_rd, bus.rf_din); end
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL starve_stall_off: got %0b want 0", bus.stall_req); end
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL starve_after_ready: got %0b want 1", bus.mdu_ready); end
    @(negedge clk);
    drive_idle();
    n_cmp++; if (bus.rf_rd !== 5'd6 || bus.rf_din !== 32'h66) begin n_fail++; $display("FAIL starve_mdu6: got rd=%0d din=%h want rd=6 din=66", bus.rf_rd, bus.rf_din); end
  endtask

  task automatic test_rd0();
    @(negedge clk);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd0; bus.mdu_data = 32'h0000_DEAD;
    #1;
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_mdu_ready: got %0b want 1", bus.mdu_ready); end
    @(negedge clk);
    drive_idle();
    n_cmp++; if (bus.rf_we !== 1'b0) begin n_fail++; $display("FAIL rd0_mdu_nowr: got %0b want 0", bus.rf_we); end
    bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd0; bus.pipe_wb_data = 32'h0000_BEEF;
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd9; bus.mdu_data = 32'h0000_0099;
    #1;
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_pipe_mdu_ready: got %0b want 1", bus.mdu_ready); end
    @(negedge clk);
    drive_idle();
    n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd9 || bus.rf_din !== 32'h99) begin n_fail++; $display("FAIL rd0_mdu9: got we=%0b rd=%0d din=%h want 1/9/99", bus.rf_we, bus.rf_rd, bus.rf_din); end
    // The dropped x0 pipe request must not have advanced the starvation counter.
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd8; bus.mdu_data = 32'h88;
    for (int i = 0; i < 4; i++) begin
      bus.pipe_wb_valid = 1'b1; bus.pipe_wb_rd = 5'd20 + 5'(i); bus.pipe_wb_data = 32'(i);
      #1;
      n_cmp++; if (bus.mdu_ready !== 1'b0) begin n_fail++; $display("FAIL rd0_cnt_hold[%0d]: got %0b want 0", i, bus.mdu_ready); end
      @(negedge clk);
    end
    bus.pipe_wb_valid = 1'b0;
    #1;
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL rd0_mdu8_ready: got %0b want 1", bus.mdu_ready); end
    @(negedge clk);
    drive_idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    bus.mdu_valid = 1'b1; bus.mdu_rd = 5'd1; bus.mdu_data = 32'h11;
    #1;
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready1: got %0b want 1", bus.mdu_ready); end
    @(negedge clk);
    bus.mdu_rd = 5'd2; bus.mdu_data = 32'h22;
    n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd1 || bus.rf_din !== 32'h11) begin n_fail++; $display("FAIL b2b_wr1: got we=%0b rd=%0d din=%h want 1/1/11", bus.rf_we, bus.rf_rd, bus.rf_din); end
    #1;
    n_cmp++; if (bus.mdu_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready2: got %0b want 1", bus.mdu_ready); end
    @(negedge clk);
    drive_idle();
    n_cmp++; if (bus.rf_we !== 1'b1 || bus.rf_rd !== 5'd2 || bus.rf_din !== 32'h22) begin n_fail++; $display("FAIL b2b_wr2: got we=%0b rd=%0d din=%h want 1/2/22", bus.rf_we, bus.rf_rd, bus.rf_din); end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd4; bus.rs1_idx = 5'd4;
    @(negedge clk);
    bus.issue_valid = 1'b0;
    #1;
    n_cmp++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy4_set: got %0b want 1", bus.rs1_busy); end
    run_starve(5'd20, 1'b0);
    #1;
    n_cmp++; if (bus.stall_req !== 1'b1) begin n_fail++; $display("FAIL arst_skid_full: got %0b want 1", bus.stall_req); end
    #1;
    reset = 1'b0;
    #1;
    n_cmp++; if (bus.rf_we !== 1'b0 || bus.rf_rd !== 5'd0 || bus.rf_din !== 32'd0) begin n_fail++; $display("FAIL arst_rf: got we=%0b rd=%0d din=%h want 0/0/0", bus.rf_we, bus.rf_rd, bus.rf_din); end
    n_cmp++; if (bus.stall_req !== 1'b0) begin n_fail++; $display("FAIL arst_stall: got %0b want 0", bus.stall_req); end
    n_cmp++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy4: got %0b want 0", bus.rs1_busy); end
    @(negedge clk);
    reset = 1'b1;
    test_pipe_only("arst_pipe");
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_pipe_only("pipe");
    test_scoreboard();
    test_starvation();
    test_rd0();
    test_back_to_back();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
